// File: rtl/camera_stream_gen.sv
// camera_stream_gen: emulates the transmit side of an OV7670-style parallel
// camera. Produces PCLK (CLOCK/2), VSYNC, HREF and an RGB565 byte stream
// carrying one of four test patterns. All frame state advances only on the
// "tick", the CLOCK edge where PCLK_OUT falls, so every output is stable
// across the following PCLK rising edge.
module camera_stream_gen #(
    parameter int H_ACTIVE    = 176,
    parameter int V_ACTIVE    = 144,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [1:0]  PATTERN_SEL,
    input  logic [15:0] SOLID_RGB565,
    output logic        PCLK_OUT,
    output logic        HREF_OUT,
    output logic        VSYNC_OUT,
    output logic [7:0]  DATA_OUT,
    output logic        FRAME_DONE
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN);
    localparam int V_MAX_AB = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int V_MAX_CD = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX    = (V_MAX_AB > V_MAX_CD) ? V_MAX_AB : V_MAX_CD;
    localparam int VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam int BAR_W    = H_ACTIVE / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          phase_reg;
    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic [1:0]    pat_reg;
    logic [15:0]   solid_reg;
    logic          frame_done_reg;

    logic          tick;
    logic          line_end;
    logic          state_done;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;
    logic [31:0]   x_ext;
    logic [31:0]   v_last;
    logic [6:0]    past_edge;
    logic [2:0]    bar_idx;
    logic [7:0]    xy_sum;
    logic [15:0]   pixel;
    logic          unused_bits;

    // The tick is the edge on which the phase bit (and PCLK_OUT) falls.
    assign tick       = phase_reg;
    assign h_ext      = 32'(h_cnt_reg);
    assign v_ext      = 32'(v_cnt_reg);
    assign x_ext      = h_ext >> 1;
    assign line_end   = (h_ext == 32'(LINE_LEN - 1));
    assign state_done = line_end && (v_ext == v_last);
    assign xy_sum     = x_ext[7:0] + v_ext[7:0];
    assign unused_bits = ^xy_sum[2:0];

    assign PCLK_OUT   = phase_reg;
    assign FRAME_DONE = frame_done_reg;

    // Phase bit: free-running CLOCK/2 divider.
    always_ff @(posedge CLOCK) begin
        if (RESET) phase_reg <= 1'b0;
        else       phase_reg <= ~phase_reg;
    end

    // FSM state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Last line index of the current state's line count.
    always_comb begin
        v_last = 32'(V_FRONT - 1);
        case (state_reg)
            ST_VSYNC:  v_last = 32'(VSYNC_LINES - 1);
            ST_VBACK:  v_last = 32'(V_BACK - 1);
            ST_ACTIVE: v_last = 32'(V_ACTIVE - 1);
            default:   v_last = 32'(V_FRONT - 1);
        endcase
    end

    // FSM next state: moves only on a tick, at the end of the state's last line.
    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                ST_IDLE:   if (EN)         state_next = ST_VSYNC;
                ST_VSYNC:  if (state_done) state_next = ST_VBACK;
                ST_VBACK:  if (state_done) state_next = ST_ACTIVE;
                ST_ACTIVE: if (state_done) state_next = ST_VFRONT;
                ST_VFRONT: if (state_done) state_next = EN ? ST_VSYNC : ST_IDLE;
                default:                   state_next = ST_IDLE;
            endcase
        end
    end

    // Pixel-byte and line counters; both restart whenever the FSM changes state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (tick) begin
            if (state_reg == ST_IDLE) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= '0;
            end else begin
                h_cnt_reg <= line_end ? '0 : h_cnt_reg + HW'(1);
                if (line_end) v_cnt_reg <= state_done ? '0 : v_cnt_reg + VW'(1);
            end
        end
    end

    // Pattern selection is captured as a frame begins and held until the next one.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pat_reg   <= 2'd0;
            solid_reg <= 16'h0000;
        end else if (tick && state_next == ST_VSYNC && state_reg != ST_VSYNC) begin
            pat_reg   <= PATTERN_SEL;
            solid_reg <= SOLID_RGB565;
        end
    end

    // Frame-done pulse: high for the single CLOCK cycle after the tick leaving VFRONT.
    always_ff @(posedge CLOCK) begin
        if (RESET) frame_done_reg <= 1'b0;
        else       frame_done_reg <= tick && (state_reg == ST_VFRONT) && state_done;
    end

    // Bar boundaries form a thermometer code; the last bar absorbs the remainder.
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar_edge
        assign past_edge[gi] = (x_ext >= 32'((gi + 1) * BAR_W));
    end

    // Bar index is the number of boundaries already passed.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 0; i < 7; i++) bar_idx = bar_idx + {2'b00, past_edge[i]};
    end

    // RGB565 colour of the current pixel for the latched pattern.
    always_comb begin
        pixel = 16'h0000;
        case (pat_reg)
            2'd0: begin
                case (bar_idx)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = solid_reg;
            2'd2:    pixel = (x_ext == v_ext) ? 16'hFFFF : 16'h0000;
            default: pixel = {x_ext[7:3], v_ext[7:2], xy_sum[7:3]};
        endcase
    end

    // FSM outputs: sync levels and the byte on the bus (high byte first).
    always_comb begin
        VSYNC_OUT = (state_reg == ST_VSYNC);
        HREF_OUT  = (state_reg == ST_ACTIVE) && (h_ext < 32'(2 * H_ACTIVE));
        DATA_OUT  = 8'h00;
        if (HREF_OUT) DATA_OUT = h_cnt_reg[0] ? pixel[7:0] : pixel[15:8];
    end

endmodule

// File: tb/tb_camera_stream_gen.sv
// tb_camera_stream_gen: randomized frame-level checks of camera_stream_gen
// against a frame model built from tick position arithmetic. Uses a small
// frame geometry so several complete frames fit in a short run.
module tb_camera_stream_gen;

    localparam int HA    = 20;
    localparam int VA    = 8;
    localparam int HB    = 6;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int VF    = 1;
    localparam int LINE  = 2 * HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LINE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid = 16'h0000;
    logic        pclk;
    logic        href;
    logic        vsync;
    logic [7:0]  data;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    camera_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .CLOCK(clk), .RESET(rst), .EN(en), .PATTERN_SEL(pattern_sel),
        .SOLID_RGB565(solid), .PCLK_OUT(pclk), .HREF_OUT(href),
        .VSYNC_OUT(vsync), .DATA_OUT(data), .FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    // Reference colour of pixel (x, y) straight from the pattern definitions.
    function automatic logic [15:0] model_color(input int pat, input logic [15:0] sol,
                                                input int x, input int y);
        int bar, r, g, b;
        logic [15:0] c;
        c = 16'h0000;
        case (pat)
            0: begin
                bar = x / (HA / 8);
                if (bar > 7) bar = 7;
                case (bar)
                    0: c = 16'hFFFF;
                    1: c = 16'hFFE0;
                    2: c = 16'h07FF;
                    3: c = 16'h07E0;
                    4: c = 16'hF81F;
                    5: c = 16'hF800;
                    6: c = 16'h001F;
                    default: c = 16'h0000;
                endcase
            end
            1: c = sol;
            2: c = (x == y) ? 16'hFFFF : 16'h0000;
            default: begin
                r = (x % 256) / 8;
                g = (y % 256) / 4;
                b = (((x % 256) + (y % 256)) % 256) / 8;
                c = 16'(r * 2048 + g * 32 + b);
            end
        endcase
        return c;
    endfunction

    // Advance to the sample point just after the next PCLK falling edge;
    // FRAME_DONE must be low on the samples in between.
    task automatic next_tick();
        logic p;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            p = pclk;
            @(posedge clk); #1;
            if (p === 1'b1 && pclk === 1'b0) begin
                got = 1'b1;
            end else begin
                vectors++;
                if (frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL frame_done_between_ticks got %b want 0", frame_done);
                end
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL pclk_tick no falling PCLK within 4 clocks (pclk=%b)", pclk);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    endtask

    // Check n ticks of a frame starting at the tick where VSYNC should rise.
    task automatic play_frame(input int pat, input logic [15:0] sol, input bit prev_done,
                              input int n, input int drop_at, input int scramble_at);
        int line, col;
        logic        exp_vs, exp_hr, exp_fd;
        logic [7:0]  exp_d;
        logic [15:0] c;
        for (int t = 0; t < n; t++) begin
            next_tick();
            line   = t / LINE;
            col    = t % LINE;
            exp_vs = (line < VS);
            exp_hr = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2 * HA);
            exp_fd = (t == 0) && prev_done;
            exp_d  = 8'h00;
            if (exp_hr) begin
                c = model_color(pat, sol, col / 2, line - VS - VB);
                exp_d = (col % 2 == 0) ? c[15:8] : c[7:0];
            end
            vectors++;
            if (vsync !== exp_vs) begin
                miscompares++;
                $display("FAIL vsync t=%0d got %b want %b", t, vsync, exp_vs);
            end
            vectors++;
            if (href !== exp_hr) begin
                miscompares++;
                $display("FAIL href t=%0d got %b want %b", t, href, exp_hr);
            end
            vectors++;
            if (data !== exp_d) begin
                miscompares++;
                $display("FAIL data pat=%0d t=%0d got %02h want %02h", pat, t, data, exp_d);
            end
            vectors++;
            if (frame_done !== exp_fd) begin
                miscompares++;
                $display("FAIL frame_done t=%0d got %b want %b", t, frame_done, exp_fd);
            end
            if (t == drop_at) en = 1'b0;
            if (t == scramble_at) begin
                pattern_sel = 2'($urandom_range(0, 3));
                solid       = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pclk, href, vsync, data, frame_done} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs got pclk=%b href=%b vsync=%b data=%02h done=%b want all 0",
                     pclk, href, vsync, data, frame_done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (pclk !== 1'b1 || vsync !== 1'b0) begin
            miscompares++;
            $display("FAIL release_cycle1 got pclk=%b vsync=%b want 1,0", pclk, vsync);
        end
        @(posedge clk); #1;
        vectors++;
        if (pclk !== 1'b0 || vsync !== 1'b0 || href !== 1'b0) begin
            miscompares++;
            $display("FAIL first_idle_tick got pclk=%b vsync=%b href=%b want 0,0,0", pclk, vsync, href);
        end
    endtask

    task automatic test_colour_bars();
        logic [15:0] s;
        s = 16'($urandom);
        en = 1'b1;
        pattern_sel = 2'd0;
        solid = s;
        play_frame(0, s, 1'b0, FRAME, -1, 100);
    endtask

    task automatic test_solid();
        pattern_sel = 2'd1;
        solid = 16'hA5C3;
        play_frame(1, 16'hA5C3, 1'b1, FRAME, -1, (VS + VB + 3) * LINE + 7);
        pattern_sel = 2'd1;
        solid = 16'h0000;
        play_frame(1, 16'h0000, 1'b1, FRAME, -1, -1);
    endtask

    task automatic test_back_to_back();
        int pat;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            pat = (i < 2) ? 2 + i : int'($urandom_range(0, 3));
            s = 16'($urandom);
            pattern_sel = 2'(pat);
            solid = s;
            play_frame(pat, s, 1'b1, FRAME, -1, int'($urandom_range(0, FRAME - 2)));
        end
    endtask

    task automatic test_en_drop();
        int pat;
        logic [15:0] s;
        pat = int'($urandom_range(0, 3));
        s = 16'($urandom);
        pattern_sel = 2'(pat);
        solid = s;
        play_frame(pat, s, 1'b1, FRAME, (VS + VB + VA / 2) * LINE + 5, -1);
        for (int k = 0; k < 2 * LINE; k++) begin
            next_tick();
            vectors++;
            if (vsync !== 1'b0 || href !== 1'b0 || data !== 8'h00) begin
                miscompares++;
                $display("FAIL idle_outputs k=%0d got vsync=%b href=%b data=%02h want 0,0,00",
                         k, vsync, href, data);
            end
            vectors++;
            if (frame_done !== (k == 0)) begin
                miscompares++;
                $display("FAIL idle_frame_done k=%0d got %b want %b", k, frame_done, k == 0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int pat;
        logic [15:0] s;
        pat = int'($urandom_range(0, 3));
        s = 16'($urandom);
        en = 1'b1;
        pattern_sel = 2'(pat);
        solid = s;
        play_frame(pat, s, 1'b0, (VS + VB + 2) * LINE + 9, -1, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({pclk, href, vsync, data, frame_done} !== 12'h000) begin
            miscompares++;
            $display("FAIL midframe_reset got pclk=%b href=%b vsync=%b data=%02h done=%b want all 0",
                     pclk, href, vsync, data, frame_done);
        end
        pat = int'($urandom_range(0, 3));
        s = 16'($urandom);
        pattern_sel = 2'(pat);
        solid = s;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (pclk !== 1'b1 || vsync !== 1'b0 || href !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_cycle1 got pclk=%b vsync=%b href=%b want 1,0,0", pclk, vsync, href);
        end
        play_frame(pat, s, 1'b0, FRAME, (VS + VB) * LINE + 3, LINE + 1);
        for (int k = 0; k < 8; k++) begin
            next_tick();
            vectors++;
            if (frame_done !== (k == 0) || vsync !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_end k=%0d got done=%b vsync=%b want %b,0",
                         k, frame_done, vsync, k == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_colour_bars();
        test_solid();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
